// File: rtl/aes_byte_io.sv
// rtl/aes_byte_io.sv - byte-serial host front end for the masked AES core
module aes_byte_io #(
  parameter int NB = 16
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            EN,
  input  logic            Kwe,
  input  logic [7:0]      Kbyte,
  input  logic            Dwe,
  input  logic [7:0]      Dbyte,
  input  logic            Ord,
  output logic [7:0]      Obyte,
  output logic            Ovld,
  output logic            Kok,
  output logic            Busy,
  output logic [8*NB-1:0] core_Kin,
  output logic            core_Krdy,
  input  logic            core_Kvld,
  output logic [8*NB-1:0] core_Din,
  output logic            core_Drdy,
  input  logic            core_Dvld,
  input  logic [8*NB-1:0] core_Dout,
  input  logic            core_BSY
);

  localparam int W = 8 * NB;
  localparam logic [4:0] FULL = 5'(NB);

  typedef enum logic [2:0] {IDLE, KSTART, KWAIT, DSTART, DWAIT} state_e;

  state_e         state_q, state_d;
  logic [4:0]     kcnt_q, dcnt_q, ocnt_q;
  logic [W-1:0]   kin_q, din_q, obuf_q;
  logic           ovld_q, kok_q;
  logic           k_acc, d_acc, cap, rd;

  // Host writes land only while idle and the counter has room; extra bytes drop silently.
  assign k_acc = EN && (state_q == IDLE) && (kcnt_q < FULL) && Kwe;
  assign d_acc = EN && (state_q == IDLE) && (dcnt_q < FULL) && Dwe;
  assign cap   = EN && (state_q == DWAIT) && core_Dvld;
  assign rd    = EN && ovld_q && Ord;

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; key load wins over data, and data waits for ciphertext to drain
  always_comb begin
    state_d = state_q;
    if (EN) begin
      case (state_q)
        IDLE: begin
          if (kcnt_q == FULL)
            state_d = KSTART;
          else if ((dcnt_q == FULL) && kok_q && !ovld_q && !core_BSY)
            state_d = DSTART;
        end
        KSTART:  state_d = KWAIT;
        KWAIT:   if (core_Kvld) state_d = IDLE;
        DSTART:  state_d = DWAIT;
        DWAIT:   if (core_Dvld) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs; strobes are masked while the block is disabled
  always_comb begin
    core_Krdy = EN && (state_q == KSTART);
    core_Drdy = EN && (state_q == DSTART);
    Busy      = (state_q != IDLE);
  end

  // Key assembly and key-valid tracking
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      kcnt_q <= '0;
      kin_q  <= '0;
      kok_q  <= 1'b0;
    end else begin
      if (EN && (state_q == KSTART))
        kcnt_q <= '0;
      else if (k_acc)
        kcnt_q <= kcnt_q + 5'd1;
      if (k_acc)
        kin_q <= {kin_q[W-9:0], Kbyte};
      if (k_acc && (kcnt_q == 5'd0))
        kok_q <= 1'b0;
      else if (EN && (state_q == KWAIT) && core_Kvld)
        kok_q <= 1'b1;
    end
  end

  // Plaintext assembly; the bus only moves on accepted writes so it is stable during encryption
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      dcnt_q <= '0;
      din_q  <= '0;
    end else begin
      if (EN && (state_q == DSTART))
        dcnt_q <= '0;
      else if (d_acc)
        dcnt_q <= dcnt_q + 5'd1;
      if (d_acc)
        din_q <= {din_q[W-9:0], Dbyte};
    end
  end

  // Ciphertext capture and byte-wise readout; the last read empties the buffer
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      obuf_q <= '0;
      ocnt_q <= '0;
      ovld_q <= 1'b0;
    end else if (cap) begin
      obuf_q <= core_Dout;
      ocnt_q <= '0;
      ovld_q <= 1'b1;
    end else if (rd) begin
      obuf_q <= {obuf_q[W-9:0], 8'h00};
      ocnt_q <= ocnt_q + 5'd1;
      if (ocnt_q == FULL - 5'd1)
        ovld_q <= 1'b0;
    end
  end

  assign Obyte    = obuf_q[W-1 -: 8];
  assign Ovld     = ovld_q;
  assign Kok      = kok_q;
  assign core_Kin = kin_q;
  assign core_Din = din_q;

endmodule

// File: tb/tb_aes_byte_io.sv
// tb/tb_aes_byte_io.sv - directed self-checking bench for aes_byte_io
module tb_aes_byte_io;

  logic         CLK = 1'b0;
  logic         RSTn, EN, Kwe, Dwe, Ord;
  logic [7:0]   Kbyte, Dbyte;
  logic [7:0]   Obyte;
  logic         Ovld, Kok, Busy;
  logic [127:0] core_Kin, core_Din, core_Dout;
  logic         core_Krdy, core_Kvld, core_Drdy, core_Dvld, core_BSY;

  int total = 0;
  int bad   = 0;
  int krdy_n = 0;
  int drdy_n = 0;

  logic [127:0] ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [127:0] p2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  aes_byte_io #(.NB(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN),
    .Kwe(Kwe), .Kbyte(Kbyte), .Dwe(Dwe), .Dbyte(Dbyte), .Ord(Ord),
    .Obyte(Obyte), .Ovld(Ovld), .Kok(Kok), .Busy(Busy),
    .core_Kin(core_Kin), .core_Krdy(core_Krdy), .core_Kvld(core_Kvld),
    .core_Din(core_Din), .core_Drdy(core_Drdy), .core_Dvld(core_Dvld),
    .core_Dout(core_Dout), .core_BSY(core_BSY)
  );

  always #5 CLK = ~CLK;

  // Strobe pulse counters, sampled mid-cycle
  always @(negedge CLK) begin
    if (core_Krdy) krdy_n <= krdy_n + 1;
    if (core_Drdy) drdy_n <= drdy_n + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RSTn = 1'b0; EN = 1'b1; Kwe = 1'b0; Dwe = 1'b0; Ord = 1'b0;
    Kbyte = 8'h00; Dbyte = 8'h00; core_Kvld = 1'b0; core_Dvld = 1'b0;
    core_Dout = '0; core_BSY = 1'b0;
    repeat (2) tick;
    RSTn = 1'b1;

    chk("rst_obyte", Obyte, 0);
    chk("rst_ovld", Ovld, 0);
    chk("rst_kok", Kok, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_krdy", core_Krdy, 0);
    chk("rst_drdy", core_Drdy, 0);
    chk("rst_kin", core_Kin, 0);
    chk("rst_din", core_Din, 0);

    // Key load 00..0f
    for (int i = 0; i < 16; i++) begin
      Kwe = 1'b1; Kbyte = 8'(i); tick;
    end
    Kwe = 1'b0;
    chk("kin_load", core_Kin, 128'h000102030405060708090a0b0c0d0e0f);
    chk("krdy_t0", core_Krdy, 0);
    tick;
    chk("krdy_t1", core_Krdy, 1);
    chk("busy_kstart", Busy, 1);
    tick;
    chk("krdy_t2", core_Krdy, 0);
    chk("busy_kwait", Busy, 1);
    core_Kvld = 1'b1; tick; core_Kvld = 1'b0;
    chk("kok_set", Kok, 1);
    chk("busy_idle", Busy, 0);
    chk("krdy_count", krdy_n, 1);

    // Stray Dvld while idle
    core_Dout = ct; core_Dvld = 1'b1; tick; core_Dvld = 1'b0;
    chk("dvld_idle_ign", Ovld, 0);

    // Encryption of the standard test vector
    for (int i = 0; i < 16; i++) begin
      Dwe = 1'b1; Dbyte = 8'(i * 17); tick;
    end
    Dwe = 1'b0;
    chk("din_load", core_Din, 128'h00112233445566778899aabbccddeeff);
    chk("drdy_t0", core_Drdy, 0);
    tick;
    chk("drdy_t1", core_Drdy, 1);
    tick;
    chk("drdy_t2", core_Drdy, 0);
    core_Dvld = 1'b1; tick; core_Dvld = 1'b0;
    chk("ovld_cap", Ovld, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ct_byte%0d", i), Obyte, ct[127 - 8*i -: 8]);
      Ord = 1'b1; tick;
    end
    Ord = 1'b0;
    chk("ovld_drained", Ovld, 0);
    chk("drdy_count1", drdy_n, 1);
    Ord = 1'b1; tick; Ord = 1'b0;
    chk("ord_empty_ovld", Ovld, 0);
    chk("ord_empty_obyte", Obyte, 0);

    // Gating on Kok, simultaneous writes, 17th data byte
    Kwe = 1'b1; Kbyte = 8'h20; Dwe = 1'b1; Dbyte = 8'ha0; tick;
    Kwe = 1'b0;
    chk("kok_cleared", Kok, 0);
    for (int i = 1; i < 16; i++) begin
      Dbyte = 8'(8'ha0 + i); tick;
    end
    Dbyte = 8'hee; tick;
    Dwe = 1'b0;
    chk("din_17th_ign", core_Din, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
    repeat (4) tick;
    chk("drdy_gated", drdy_n, 1);
    chk("busy_gated", Busy, 0);
    for (int i = 1; i < 16; i++) begin
      Kwe = 1'b1; Kbyte = 8'(8'h20 + i); tick;
    end
    Kwe = 1'b0;
    chk("kin_simul", core_Kin, 128'h202122232425262728292a2b2c2d2e2f);
    tick;
    chk("krdy_key2", core_Krdy, 1);
    tick;
    core_Kvld = 1'b1; tick; core_Kvld = 1'b0;
    chk("kok_key2", Kok, 1);
    chk("drdy_after_kok0", core_Drdy, 0);
    tick;
    chk("drdy_after_kok1", core_Drdy, 1);
    tick;
    chk("drdy_after_kok2", core_Drdy, 0);
    chk("drdy_count2", drdy_n, 2);

    // EN=0 in DWAIT
    EN = 1'b0; core_Dout = p2; core_Dvld = 1'b1; tick; core_Dvld = 1'b0;
    chk("en0_ovld", Ovld, 0);
    chk("en0_busy", Busy, 1);
    chk("en0_drdy", core_Drdy, 0);
    EN = 1'b1; core_Dvld = 1'b1; tick; core_Dvld = 1'b0;
    chk("en1_ovld", Ovld, 1);
    chk("en1_obyte", Obyte, 8'h0f);

    // Overlap: load next block with ciphertext pending
    for (int i = 0; i < 16; i++) begin
      Dwe = 1'b1; Dbyte = 8'(8'h30 + i); tick;
    end
    Dwe = 1'b0;
    chk("din_overlap", core_Din, 128'h303132333435363738393a3b3c3d3e3f);
    repeat (3) tick;
    chk("overlap_held", drdy_n, 2);
    chk("overlap_busy", Busy, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("p2_byte%0d", i), Obyte, p2[127 - 8*i -: 8]);
      Ord = 1'b1; tick;
      chk($sformatf("overlap_drdy%0d", i), core_Drdy, 0);
    end
    Ord = 1'b0;
    chk("overlap_ovld", Ovld, 0);
    tick;
    chk("overlap_drdy_fire", core_Drdy, 1);
    tick;
    chk("overlap_dwait", Busy, 1);

    // Reset in DWAIT
    RSTn = 1'b0; #1;
    chk("arst_busy", Busy, 0);
    chk("arst_kok", Kok, 0);
    chk("arst_kin", core_Kin, 0);
    chk("arst_din", core_Din, 0);
    chk("arst_obyte", Obyte, 0);
    chk("arst_ovld", Ovld, 0);
    tick;
    RSTn = 1'b1;
    core_Dout = ct; core_Dvld = 1'b1; tick; core_Dvld = 1'b0;
    chk("post_rst_dvld", Ovld, 0);
    chk("post_rst_busy", Busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
